// File: rtl/mux4_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux4_rr_arbiter_pkg
//  Description : Shared definitions for the 4-way round-robin mux arbiter:
//                requester count, FSM state encoding, default parameter
//                values and the round-robin winner search.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ           = 4;
    localparam int DEFAULT_DATA_W    = 8;
    localparam int DEFAULT_MAX_BURST = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Scan ptr+1 .. ptr+4 (mod 4); the first requester with req high wins.
    // The pointer itself is visited last, so the previous owner has the
    // lowest priority.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [1:0]         ptr);
        pick_t      p;
        logic [1:0] cand;
        p.found = 1'b0;
        p.idx   = 2'd0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ptr + 2'(i);
            if (!p.found && req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux4_rr_arbiter_if
//  Description : Requester/arbiter bundle.
//                req       - per-requester beat request (4 bits)
//                in_data   - requester data, slice k = in_data[k*DATA_W +: DATA_W]
//                gnt       - registered one-hot grant
//                sel       - registered mux select (granted index)
//                out_valid - registered, one cycle per transferred beat
//                out_data  - registered data of last transferred beat
//                master modport: requester side; slave modport: arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux4_rr_arbiter_if #(
    parameter int DATA_W = 8
);
    import mux4_rr_arbiter_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [1:0]                sel;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;

    modport master (
        output req, in_data,
        input  gnt, sel, out_valid, out_data
    );

    modport slave (
        input  req, in_data,
        output gnt, sel, out_valid, out_data
    );

endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter_mux4_w.sv
`default_nettype none
// ============================================================================
//  Module      : mux4_w
//  Description : DATA_W-wide combinational 4:1 mux.
//                in_data  - four packed DATA_W slices, slice k selected by k
//                sel      - 2-bit select
//                out_data - selected slice
//  Revision    : 1.0 - initial release
// ============================================================================
module mux4_w #(
    parameter int DATA_W = 8
) (
    input  wire logic [4*DATA_W-1:0] in_data,
    input  wire logic [1:0]          sel,
    output logic      [DATA_W-1:0]   out_data
);

    always_comb begin
        out_data = in_data[sel*DATA_W +: DATA_W];
    end

endmodule
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux4_rr_arbiter
//  Description : Round-robin arbiter sharing one DATA_W-wide 4:1 mux output
//                between four requesters. Each grant lasts up to MAX_BURST
//                beats; the selected beat is registered onto out_data.
//                Ports: clk, rst_n (async, active low), bus (slave modport of
//                mux4_rr_arbiter_if).
//                Optional: MUX4_ARB_STATS_EN adds grant_cnt (4 x 16-bit
//                saturating per-requester beat counters).
//  Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    mux4_rr_arbiter_if.slave       bus
`ifdef MUX4_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]  grant_cnt
`endif
);

    localparam int                 c_CNT_W     = $clog2(MAX_BURST) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);

    state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [1:0]           r_sel, w_sel_nxt;
    logic [1:0]           r_last, w_last_nxt;
    logic [c_CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic                 r_out_valid, w_out_valid_nxt;
    logic [DATA_W-1:0]    r_out_data, w_out_data_nxt;

    logic                 w_beat;
    logic [DATA_W-1:0]    w_mux_data;
    pick_t                w_pick_idle;
    pick_t                w_pick_rel;

    mux4_w #(.DATA_W(DATA_W)) u_mux (
        .in_data  (bus.in_data),
        .sel      (r_sel),
        .out_data (w_mux_data)
    );

    // From IDLE the pointer is the last owner; on release the current owner
    // becomes the pointer, so it is scanned last when re-arbitrating.
    assign w_pick_idle = rr_pick(bus.req, r_last);
    assign w_pick_rel  = rr_pick(bus.req, r_sel);

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_sel_nxt       = r_sel;
        w_last_nxt      = r_last;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_out_valid_nxt = 1'b0;
        w_out_data_nxt  = r_out_data;
        w_beat          = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_idle.found) begin
                    w_state_nxt    = GRANT;
                    w_gnt_nxt      = onehot4(w_pick_idle.idx);
                    w_sel_nxt      = w_pick_idle.idx;
                    w_beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                w_beat = bus.req[r_sel];
                if (w_beat) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = w_mux_data;
                    w_beat_cnt_nxt  = r_beat_cnt + c_CNT_W'(1);
                end
                // Release either because the owner went quiet or because it
                // just spent its last allowed beat of this burst.
                if (!w_beat || (r_beat_cnt == c_LAST_BEAT)) begin
                    w_last_nxt     = r_sel;
                    w_beat_cnt_nxt = '0;
                    if (w_pick_rel.found) begin
                        w_gnt_nxt = onehot4(w_pick_rel.idx);
                        w_sel_nxt = w_pick_rel.idx;
                    end else begin
                        w_gnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_sel       <= 2'd0;
            r_last      <= 2'd3;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_sel       <= w_sel_nxt;
            r_last      <= w_last_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.sel       = r_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

`ifdef MUX4_ARB_STATS_EN
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
        logic [15:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= 16'd0;
            end else if (w_beat && (r_sel == 2'(k)) && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign grant_cnt[k*16 +: 16] = r_cnt;
    end
`endif

endmodule
`default_nettype wire
